// File: rtl/bash_io_pkg.sv
// Shared ASCII codes, line limit and line-state encoding for the bash console path.
// Pure declarations; no latency or backpressure.
package bash_io_pkg;

    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_DEL = 8'h7F;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_NUL = 8'h00;
    localparam logic [7:0] ASCII_SP  = 8'h20;
    localparam logic [7:0] ASCII_TLD = 8'h7E;
    localparam int         LINE_MAX  = 32;

    typedef enum logic {
        ST_EDIT = 1'b0,
        ST_SEND = 1'b1
    } line_state_e;

endpackage

// File: rtl/line_buffer_ram.sv
// Line storage: one synchronous write port, one asynchronous read port, no reset.
// Write lands on the clock edge; read is combinational; never stalls.
module line_buffer_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bash_line_collector.sv
// Collects keystrokes into a line (backspace, echo), then streams it NUL-terminated on Enter.
// Key effects appear 1 cycle later; keys arriving while a line is in flight are dropped.
module bash_line_collector
    import bash_io_pkg::*;
#(
    parameter int MAX_LEN = LINE_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [7:0] key_ascii,
    output logic       line_ready,
    output logic [5:0] line_len,
    output logic [7:0] line_char,
    input  logic       line_next,
    output logic       echo_valid,
    output logic [7:0] echo_ascii,
    output logic       key_dropped
);

    localparam int         AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         DEPTH   = 1 << AW;
    localparam logic [5:0] LEN_CAP = 6'(MAX_LEN);

    line_state_e r_state, w_state_nxt;
    logic [5:0]  r_wr_ptr, w_wr_ptr_nxt;
    logic [5:0]  r_rd_ptr, w_rd_ptr_nxt;
    logic [5:0]  r_line_len, w_line_len_nxt;
    logic        r_line_ready, w_line_ready_nxt;
    logic        r_echo_vld, w_echo_vld_nxt;
    logic [7:0]  r_echo_ascii, w_echo_ascii_nxt;
    logic        r_key_dropped, w_key_dropped_nxt;
    logic        w_wr_en;
    logic [7:0]  w_rd_dat;
    logic        w_is_print, w_is_bs, w_is_enter;

    assign w_is_print = (key_ascii >= ASCII_SP) && (key_ascii <= ASCII_TLD);
    assign w_is_bs    = (key_ascii == ASCII_BS) || (key_ascii == ASCII_DEL);
    assign w_is_enter = (key_ascii == ASCII_CR) || (key_ascii == ASCII_LF);

    line_buffer_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (key_ascii),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rd_dat)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_wr_ptr_nxt      = r_wr_ptr;
        w_rd_ptr_nxt      = r_rd_ptr;
        w_line_len_nxt    = r_line_len;
        w_line_ready_nxt  = r_line_ready;
        w_echo_vld_nxt    = 1'b0;
        w_echo_ascii_nxt  = r_echo_ascii;
        w_key_dropped_nxt = 1'b0;
        w_wr_en           = 1'b0;
        case (r_state)
            ST_EDIT: begin
                if (key_valid) begin
                    if (w_is_print) begin
                        if (r_wr_ptr < LEN_CAP) begin
                            w_wr_en          = 1'b1;
                            w_wr_ptr_nxt     = r_wr_ptr + 6'd1;
                            w_echo_vld_nxt   = 1'b1;
                            w_echo_ascii_nxt = key_ascii;
                        end else begin
                            w_key_dropped_nxt = 1'b1;
                        end
                    end else if (w_is_bs) begin
                        if (r_wr_ptr != 6'd0) begin
                            w_wr_ptr_nxt     = r_wr_ptr - 6'd1;
                            w_echo_vld_nxt   = 1'b1;
                            w_echo_ascii_nxt = ASCII_BS;
                        end
                    end else if (w_is_enter) begin
                        w_line_len_nxt   = r_wr_ptr;
                        w_rd_ptr_nxt     = 6'd0;
                        w_line_ready_nxt = 1'b1;
                        w_echo_vld_nxt   = 1'b1;
                        w_echo_ascii_nxt = ASCII_LF;
                        w_state_nxt      = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                // Keys are never buffered across a line hand-off, even on the final next.
                w_key_dropped_nxt = key_valid;
                if (line_next) begin
                    if (r_rd_ptr < r_line_len) begin
                        w_rd_ptr_nxt = r_rd_ptr + 6'd1;
                    end else begin
                        w_line_ready_nxt = 1'b0;
                        w_wr_ptr_nxt     = 6'd0;
                        w_rd_ptr_nxt     = 6'd0;
                        w_state_nxt      = ST_EDIT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_EDIT;
            r_wr_ptr      <= 6'd0;
            r_rd_ptr      <= 6'd0;
            r_line_len    <= 6'd0;
            r_line_ready  <= 1'b0;
            r_echo_vld    <= 1'b0;
            r_echo_ascii  <= 8'h00;
            r_key_dropped <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_rd_ptr      <= w_rd_ptr_nxt;
            r_line_len    <= w_line_len_nxt;
            r_line_ready  <= w_line_ready_nxt;
            r_echo_vld    <= w_echo_vld_nxt;
            r_echo_ascii  <= w_echo_ascii_nxt;
            r_key_dropped <= w_key_dropped_nxt;
        end
    end

    assign line_ready  = r_line_ready;
    assign line_len    = r_line_len;
    assign line_char   = (r_line_ready && (r_rd_ptr != r_line_len)) ? w_rd_dat : ASCII_NUL;
    assign echo_valid  = r_echo_vld;
    assign echo_ascii  = r_echo_ascii;
    assign key_dropped = r_key_dropped;

endmodule

// File: tb/tb_bash_line_collector.sv
// Directed bench for bash_line_collector: typing, backspace, overflow, empty line, reset abort.
module tb_bash_line_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid;
    logic [7:0] key_ascii;
    logic       line_ready;
    logic [5:0] line_len;
    logic [7:0] line_char;
    logic       line_next;
    logic       echo_valid;
    logic [7:0] echo_ascii;
    logic       key_dropped;

    int checks   = 0;
    int failures = 0;

    bash_line_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_ascii   (key_ascii),
        .line_ready  (line_ready),
        .line_len    (line_len),
        .line_char   (line_char),
        .line_next   (line_next),
        .echo_valid  (echo_valid),
        .echo_ascii  (echo_ascii),
        .key_dropped (key_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One keystroke in one cycle; checks the registered response at the following negedge.
    task automatic key(input logic [7:0] k, input logic ev, input logic [7:0] ea, input logic dr);
        key_valid = 1'b1;
        key_ascii = k;
        @(negedge clk);
        key_valid = 1'b0;
        chk("echo_valid", 32'(echo_valid), 32'(ev));
        if (ev) chk("echo_ascii", 32'(echo_ascii), 32'(ea));
        chk("key_dropped", 32'(key_dropped), 32'(dr));
    endtask

    task automatic nxt();
        line_next = 1'b1;
        @(negedge clk);
        line_next = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_ascii = 8'h00;
        line_next = 1'b0;
        idle(2);
        chk("rst_line_ready", 32'(line_ready), 32'd0);
        chk("rst_line_len", 32'(line_len), 32'd0);
        chk("rst_line_char", 32'(line_char), 32'd0);
        chk("rst_echo_valid", 32'(echo_valid), 32'd0);
        chk("rst_echo_ascii", 32'(echo_ascii), 32'd0);
        chk("rst_key_dropped", 32'(key_dropped), 32'd0);
        rst_n = 1'b1;
        idle(1);

        // "ls" + CR, consumer pulses every 3 cycles
        key("l", 1, "l", 0);
        key("s", 1, "s", 0);
        key(8'h0D, 1, 8'h0A, 0);
        chk("ls_ready", 32'(line_ready), 32'd1);
        chk("ls_len", 32'(line_len), 32'd2);
        chk("ls_char0", 32'(line_char), 32'(8'h6C));
        idle(2);
        chk("ls_echo_quiet", 32'(echo_valid), 32'd0);
        nxt();
        chk("ls_char1", 32'(line_char), 32'(8'h73));
        idle(2);
        nxt();
        chk("ls_char2", 32'(line_char), 32'd0);
        chk("ls_ready_hold", 32'(line_ready), 32'd1);
        idle(2);
        nxt();
        chk("ls_ready_fall", 32'(line_ready), 32'd0);
        chk("ls_len_hold", 32'(line_len), 32'd2);

        // next while idle is ignored; BS on empty line and a control code are silent
        nxt();
        chk("idle_next_ready", 32'(line_ready), 32'd0);
        key(8'h08, 0, 8'h00, 0);
        key(8'h7F, 0, 8'h00, 0);
        key(8'h01, 0, 8'h00, 0);

        // "ab", BS, "c", CR -> "ac"
        key("a", 1, "a", 0);
        key("b", 1, "b", 0);
        key(8'h08, 1, 8'h08, 0);
        key("c", 1, "c", 0);
        key(8'h0A, 1, 8'h0A, 0);
        chk("ac_len", 32'(line_len), 32'd2);
        chk("ac_char0", 32'(line_char), 32'(8'h61));
        nxt();
        chk("ac_char1", 32'(line_char), 32'(8'h63));
        nxt();
        chk("ac_char2", 32'(line_char), 32'd0);
        nxt();
        chk("ac_done", 32'(line_ready), 32'd0);

        // 33 printable chars: the last one is dropped
        for (int i = 0; i < 32; i++) key(8'h21 + 8'(i), 1, 8'h21 + 8'(i), 0);
        key("Z", 0, 8'h00, 1);
        key(8'h0D, 1, 8'h0A, 0);
        chk("full_len", 32'(line_len), 32'd32);
        for (int i = 0; i < 32; i++) begin
            chk("full_char", 32'(line_char), 32'(8'h21 + 8'(i)));
            nxt();
        end
        chk("full_nul", 32'(line_char), 32'd0);
        chk("full_ready", 32'(line_ready), 32'd1);
        nxt();
        chk("full_done", 32'(line_ready), 32'd0);

        // empty line
        key(8'h0D, 1, 8'h0A, 0);
        chk("empty_ready", 32'(line_ready), 32'd1);
        chk("empty_len", 32'(line_len), 32'd0);
        chk("empty_char", 32'(line_char), 32'd0);
        nxt();
        chk("empty_done", 32'(line_ready), 32'd0);

        // key during SEND, coinciding with the final next
        key("k", 1, "k", 0);
        key(8'h0D, 1, 8'h0A, 0);
        key("y", 0, 8'h00, 1);
        nxt();
        chk("k_nul", 32'(line_char), 32'd0);
        line_next = 1'b1;
        key("x", 0, 8'h00, 1);
        line_next = 1'b0;
        chk("x_ready", 32'(line_ready), 32'd0);
        key("q", 1, "q", 0);
        key(8'h0D, 1, 8'h0A, 0);
        chk("q_len", 32'(line_len), 32'd1);
        chk("q_char", 32'(line_char), 32'(8'h71));
        nxt();
        nxt();
        chk("q_done", 32'(line_ready), 32'd0);

        // reset mid-stream
        key("m", 1, "m", 0);
        key("n", 1, "n", 0);
        key(8'h0D, 1, 8'h0A, 0);
        nxt();
        chk("mn_char1", 32'(line_char), 32'(8'h6E));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(line_ready), 32'd0);
        chk("arst_len", 32'(line_len), 32'd0);
        chk("arst_char", 32'(line_char), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        key("z", 1, "z", 0);
        key(8'h0D, 1, 8'h0A, 0);
        chk("z_len", 32'(line_len), 32'd1);
        chk("z_char0", 32'(line_char), 32'(8'h7A));
        nxt();
        chk("z_nul", 32'(line_char), 32'd0);
        nxt();
        chk("z_done", 32'(line_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
